// File: rtl/spi_rb_bridge_prm.sv
// SPI-to-regbank bridge: a header word selects read/write burst mode and start address;
// each data word reads back the regbank and optionally writes it. Optional read timeout: SPI_RB_TIMEOUT_EN.
module spi_rb_bridge_prm #(
    parameter int K_ADDR_W   = 8,
    parameter int K_DATA_W   = 16,
    parameter int K_AUTO_INC = 1,
    parameter int K_TIMEOUT  = 15
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [K_DATA_W-1:0] i_spi_in_data,
    input  logic                i_spi_rx,
    input  logic                i_csn,
    output logic [K_DATA_W-1:0] o_spi_out_data,
    output logic                o_spi_valid_tx,
    output logic [K_ADDR_W-1:0] o_rb_rd_addr,
    output logic                o_rb_rd_en,
    input  logic [K_DATA_W-1:0] i_rb_rd_data,
    input  logic                i_rb_rd_valid,
    output logic [K_ADDR_W-1:0] o_rb_wr_addr,
    output logic [K_DATA_W-1:0] o_rb_wr_data,
    output logic [K_DATA_W-1:0] o_rb_wr_bmask,
    output logic                o_rb_wr_en,
    output logic                o_err,
    output logic [15:0]         o_xfer_cnt
);

    localparam int CMD_W = K_DATA_W - K_ADDR_W;
    localparam logic [CMD_W-1:0]    CMD_READ        = CMD_W'(1);
    localparam logic [CMD_W-1:0]    CMD_WRITE       = CMD_W'(2);
    localparam logic [CMD_W-1:0]    CMD_READ_FIXED  = CMD_W'(3);
    localparam logic [CMD_W-1:0]    CMD_WRITE_FIXED = CMD_W'(4);
    localparam logic [K_ADDR_W-1:0] ADDR_ONE        = K_ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        RB_REQ,
        SPI_SEND,
        SPI_WAIT,
        SPI_RCV,
        ERROR
    } state_t;

    state_t              state, state_nxt;
    logic [K_ADDR_W-1:0] addr, addr_nxt;
    logic                wr_mode, wr_mode_nxt;
    logic                fixed_mode, fixed_mode_nxt;

    logic [K_ADDR_W-1:0] rd_addr_nxt, wr_addr_nxt;
    logic [K_DATA_W-1:0] out_data_nxt, wr_data_nxt;
    logic                rd_en_nxt, valid_tx_nxt, wr_en_nxt, err_nxt;
    logic [15:0]         xfer_cnt_nxt;

    logic [CMD_W-1:0]    hdr_cmd;
    logic [K_ADDR_W-1:0] hdr_addr;

    assign hdr_cmd       = i_spi_in_data[K_DATA_W-1:K_ADDR_W];
    assign hdr_addr      = i_spi_in_data[K_ADDR_W-1:0];
    assign o_rb_wr_bmask = '1;

`ifdef SPI_RB_TIMEOUT_EN
    localparam int TMO_W = (K_TIMEOUT > 1) ? $clog2(K_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(K_TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
`endif

    always_comb begin
        state_nxt      = state;
        addr_nxt       = addr;
        wr_mode_nxt    = wr_mode;
        fixed_mode_nxt = fixed_mode;
        rd_en_nxt      = 1'b0;
        rd_addr_nxt    = o_rb_rd_addr;
        valid_tx_nxt   = 1'b0;
        out_data_nxt   = o_spi_out_data;
        wr_en_nxt      = 1'b0;
        wr_addr_nxt    = o_rb_wr_addr;
        wr_data_nxt    = o_rb_wr_data;
        err_nxt        = o_err;
        xfer_cnt_nxt   = o_xfer_cnt;
`ifdef SPI_RB_TIMEOUT_EN
        tmo_nxt        = tmo_cnt;
`endif

        case (state)
            IDLE: begin
                if (i_spi_rx && !i_csn) begin
                    case (hdr_cmd)
                        CMD_READ, CMD_WRITE, CMD_READ_FIXED, CMD_WRITE_FIXED: begin
                            state_nxt      = RB_REQ;
                            addr_nxt       = hdr_addr;
                            wr_mode_nxt    = (hdr_cmd == CMD_WRITE) || (hdr_cmd == CMD_WRITE_FIXED);
                            fixed_mode_nxt = (hdr_cmd == CMD_READ_FIXED) || (hdr_cmd == CMD_WRITE_FIXED);
                        end
                        default: begin
                            state_nxt    = ERROR;
                            err_nxt      = 1'b1;
                            out_data_nxt = '1;
                        end
                    endcase
                end
            end
            RB_REQ: begin
                if (i_rb_rd_valid) begin
                    state_nxt    = SPI_SEND;
                    out_data_nxt = i_rb_rd_data;
                    valid_tx_nxt = 1'b1;
                end
`ifdef SPI_RB_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_nxt    = ERROR;
                    err_nxt      = 1'b1;
                    out_data_nxt = '1;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
`endif
            end
            SPI_SEND: state_nxt = SPI_WAIT;
            SPI_WAIT: begin
                if (i_spi_rx) begin
                    state_nxt = SPI_RCV;
                    if (wr_mode) begin
                        wr_en_nxt   = 1'b1;
                        wr_data_nxt = i_spi_in_data;
                        wr_addr_nxt = addr;
                    end
                end
            end
            SPI_RCV: begin
                state_nxt = RB_REQ;
                if (o_xfer_cnt != 16'hFFFF)
                    xfer_cnt_nxt = o_xfer_cnt + 16'd1;
                if ((K_AUTO_INC != 0) && !fixed_mode)
                    addr_nxt = addr + ADDR_ONE;
            end
            ERROR: begin
                err_nxt      = 1'b1;
                out_data_nxt = '1;
            end
            default: state_nxt = IDLE;
        endcase

        // One read request per entry into RB_REQ, at the address that state will use
        if (state_nxt == RB_REQ && state != RB_REQ) begin
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = addr_nxt;
`ifdef SPI_RB_TIMEOUT_EN
            tmo_nxt     = '0;
`endif
        end

        // Deselect ends the frame and overrides anything decided above
        if (i_csn) begin
            state_nxt    = IDLE;
            rd_en_nxt    = 1'b0;
            wr_en_nxt    = 1'b0;
            err_nxt      = 1'b0;
            xfer_cnt_nxt = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            addr           <= '0;
            wr_mode        <= 1'b0;
            fixed_mode     <= 1'b0;
            o_rb_rd_en     <= 1'b0;
            o_rb_rd_addr   <= '0;
            o_spi_valid_tx <= 1'b0;
            o_spi_out_data <= '0;
            o_rb_wr_en     <= 1'b0;
            o_rb_wr_addr   <= '0;
            o_rb_wr_data   <= '0;
            o_err          <= 1'b0;
            o_xfer_cnt     <= '0;
        end else begin
            state          <= state_nxt;
            addr           <= addr_nxt;
            wr_mode        <= wr_mode_nxt;
            fixed_mode     <= fixed_mode_nxt;
            o_rb_rd_en     <= rd_en_nxt;
            o_rb_rd_addr   <= rd_addr_nxt;
            o_spi_valid_tx <= valid_tx_nxt;
            o_spi_out_data <= out_data_nxt;
            o_rb_wr_en     <= wr_en_nxt;
            o_rb_wr_addr   <= wr_addr_nxt;
            o_rb_wr_data   <= wr_data_nxt;
            o_err          <= err_nxt;
            o_xfer_cnt     <= xfer_cnt_nxt;
        end
    end

`ifdef SPI_RB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_nxt;
    end
`endif

endmodule

// File: tb/tb_spi_rb_bridge_prm.sv
// Directed bench for spi_rb_bridge_prm: vector table for single/burst transfers,
// hand-written sequences for fixed bursts, errors, deselect races, reset and timeout.
module tb_spi_rb_bridge_prm;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_spi_in_data;
    logic        i_spi_rx;
    logic        i_csn;
    logic [15:0] o_spi_out_data;
    logic        o_spi_valid_tx;
    logic [7:0]  o_rb_rd_addr;
    logic        o_rb_rd_en;
    logic [15:0] i_rb_rd_data;
    logic        i_rb_rd_valid;
    logic [7:0]  o_rb_wr_addr;
    logic [15:0] o_rb_wr_data;
    logic [15:0] o_rb_wr_bmask;
    logic        o_rb_wr_en;
    logic        o_err;
    logic [15:0] o_xfer_cnt;

    int checks = 0;
    int errors = 0;

    spi_rb_bridge_prm dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_spi_in_data  (i_spi_in_data),
        .i_spi_rx       (i_spi_rx),
        .i_csn          (i_csn),
        .o_spi_out_data (o_spi_out_data),
        .o_spi_valid_tx (o_spi_valid_tx),
        .o_rb_rd_addr   (o_rb_rd_addr),
        .o_rb_rd_en     (o_rb_rd_en),
        .i_rb_rd_data   (i_rb_rd_data),
        .i_rb_rd_valid  (i_rb_rd_valid),
        .o_rb_wr_addr   (o_rb_wr_addr),
        .o_rb_wr_data   (o_rb_wr_data),
        .o_rb_wr_bmask  (o_rb_wr_bmask),
        .o_rb_wr_en     (o_rb_wr_en),
        .o_err          (o_err),
        .o_xfer_cnt     (o_xfer_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Packed view: {rd_en, rd_addr, valid_tx, out_data, wr_en, wr_addr, wr_data, err, xfer_cnt}
    typedef struct {
        string       name;
        logic        rx;
        logic        csn;
        logic [15:0] din;
        logic        rv;
        logic [15:0] rdata;
        logic [67:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [67:0] outs();
        return {o_rb_rd_en, o_rb_rd_addr, o_spi_valid_tx, o_spi_out_data,
                o_rb_wr_en, o_rb_wr_addr, o_rb_wr_data, o_err, o_xfer_cnt};
    endfunction

    function automatic void addVec(string name, logic rx, logic csn, logic [15:0] din,
                                   logic rv, logic [15:0] rdata,
                                   logic rd_en, logic [7:0] rd_addr, logic vtx, logic [15:0] out,
                                   logic wr_en, logic [7:0] wa, logic [15:0] wd,
                                   logic err, logic [15:0] cnt);
        vec_t v;
        v.name = name; v.rx = rx; v.csn = csn; v.din = din; v.rv = rv; v.rdata = rdata;
        v.exp = {rd_en, rd_addr, vtx, out, wr_en, wa, wd, err, cnt};
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic rx, input logic csn, input logic [15:0] din,
                                 input logic rv, input logic [15:0] rdata);
        i_spi_rx      = rx;
        i_csn         = csn;
        i_spi_in_data = din;
        i_rb_rd_valid = rv;
        i_rb_rd_data  = rdata;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [67:0] act, input logic [67:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One read beat followed by the send cycle, ending in SPI_WAIT
    task automatic readBeat(input logic [15:0] rdata);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, rdata);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        tick();
    endtask

    initial begin
        i_rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
        #3;
        checkOutput("reset_outs", outs(), 68'h0);
        checkOutput("reset_bmask", {52'h0, o_rb_wr_bmask}, {52'h0, 16'hFFFF});
        tick();
        i_rst_n = 1'b1;

        //      name          rx csn din      rv rdata     rd rda   vtx out      we wa     wd       er cnt
        addVec("a_idle",      0, 1, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 16'h0000, 0, 16'd0);
        addVec("a_hdr",       1, 0, 16'h0110, 0, 16'h0000, 1, 8'h10, 0, 16'h0000, 0, 8'h00, 16'h0000, 0, 16'd0);
        addVec("a_wait1",     0, 0, 16'h0000, 0, 16'h0000, 0, 8'h10, 0, 16'h0000, 0, 8'h00, 16'h0000, 0, 16'd0);
        addVec("a_wait2",     0, 0, 16'h0000, 0, 16'h0000, 0, 8'h10, 0, 16'h0000, 0, 8'h00, 16'h0000, 0, 16'd0);
        addVec("a_rdvalid",   0, 0, 16'h0000, 1, 16'hBEEF, 0, 8'h10, 1, 16'hBEEF, 0, 8'h00, 16'h0000, 0, 16'd0);
        addVec("a_rx_ignore", 1, 0, 16'h5555, 0, 16'h0000, 0, 8'h10, 0, 16'hBEEF, 0, 8'h00, 16'h0000, 0, 16'd0);
        addVec("a_rv_ignore", 0, 0, 16'h0000, 1, 16'h1234, 0, 8'h10, 0, 16'hBEEF, 0, 8'h00, 16'h0000, 0, 16'd0);
        addVec("a_csn_end",   0, 1, 16'h0000, 0, 16'h0000, 0, 8'h10, 0, 16'hBEEF, 0, 8'h00, 16'h0000, 0, 16'd0);
        addVec("b_hdr",       1, 0, 16'h02FE, 0, 16'h0000, 1, 8'hFE, 0, 16'hBEEF, 0, 8'h00, 16'h0000, 0, 16'd0);
        addVec("b_rv1",       0, 0, 16'h0000, 1, 16'hAAAA, 0, 8'hFE, 1, 16'hAAAA, 0, 8'h00, 16'h0000, 0, 16'd0);
        addVec("b_send1",     0, 0, 16'h0000, 0, 16'h0000, 0, 8'hFE, 0, 16'hAAAA, 0, 8'h00, 16'h0000, 0, 16'd0);
        addVec("b_wr1",       1, 0, 16'h1111, 0, 16'h0000, 0, 8'hFE, 0, 16'hAAAA, 1, 8'hFE, 16'h1111, 0, 16'd0);
        addVec("b_rcv1",      0, 0, 16'h0000, 0, 16'h0000, 1, 8'hFF, 0, 16'hAAAA, 0, 8'hFE, 16'h1111, 0, 16'd1);
        addVec("b_rv2",       0, 0, 16'h0000, 1, 16'hBBBB, 0, 8'hFF, 1, 16'hBBBB, 0, 8'hFE, 16'h1111, 0, 16'd1);
        addVec("b_send2",     0, 0, 16'h0000, 0, 16'h0000, 0, 8'hFF, 0, 16'hBBBB, 0, 8'hFE, 16'h1111, 0, 16'd1);
        addVec("b_wr2",       1, 0, 16'h2222, 0, 16'h0000, 0, 8'hFF, 0, 16'hBBBB, 1, 8'hFF, 16'h2222, 0, 16'd1);
        addVec("b_rcv2_wrap", 0, 0, 16'h0000, 0, 16'h0000, 1, 8'h00, 0, 16'hBBBB, 0, 8'hFF, 16'h2222, 0, 16'd2);
        addVec("b_csn_end",   0, 1, 16'h0000, 0, 16'h0000, 0, 8'h00, 0, 16'hBBBB, 0, 8'hFF, 16'h2222, 0, 16'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rx, vecs[i].csn, vecs[i].din, vecs[i].rv, vecs[i].rdata);
            tick();
            checkOutput(vecs[i].name, outs(), vecs[i].exp);
        end

        // Fixed-address write burst: every word lands at 0x40, reads stay at 0x40
        applyStimulus(1'b1, 1'b0, 16'h0440, 1'b0, 16'h0);
        tick();
        checkOutput("c_hdr_rd", {59'h0, o_rb_rd_en, o_rb_rd_addr}, {59'h0, 1'b1, 8'h40});
        for (int w = 0; w < 3; w++) begin
            logic [15:0] word;
            word = 16'hC000 + 16'(w);
            readBeat(16'h0C00 + 16'(w));
            applyStimulus(1'b1, 1'b0, word, 1'b0, 16'h0);
            tick();
            checkOutput($sformatf("c_wr%0d", w), {43'h0, o_rb_wr_en, o_rb_wr_addr, o_rb_wr_data},
                        {43'h0, 1'b1, 8'h40, word});
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
            tick();
            checkOutput($sformatf("c_rd%0d", w), {59'h0, o_rb_rd_en, o_rb_rd_addr}, {59'h0, 1'b1, 8'h40});
        end
        checkOutput("c_xfer_cnt", {52'h0, o_xfer_cnt}, {52'h0, 16'd3});
        applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
        tick();

        // Invalid command: sticky error, no regbank traffic, until deselect
        applyStimulus(1'b1, 1'b0, 16'h7F00, 1'b0, 16'h0);
        tick();
        checkOutput("d_err_entry", {48'h0, o_rb_rd_en, o_rb_wr_en, o_err, o_spi_valid_tx, o_spi_out_data},
                    {48'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF});
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 16'h02AA, 1'b1, 16'h1357);
            tick();
            checkOutput($sformatf("d_err_hold%0d", k), {49'h0, o_rb_rd_en, o_rb_wr_en, o_err, o_spi_out_data},
                        {49'h0, 1'b0, 1'b0, 1'b1, 16'hFFFF});
        end
        applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
        tick();
        checkOutput("d_err_clear", {67'h0, o_err}, 68'h0);

        // Deselect in the same cycle as the second data word suppresses the write
        applyStimulus(1'b1, 1'b0, 16'h0220, 1'b0, 16'h0);
        tick();
        readBeat(16'h0101);
        applyStimulus(1'b1, 1'b0, 16'h3333, 1'b0, 16'h0);
        tick();
        checkOutput("e_wr1", {43'h0, o_rb_wr_en, o_rb_wr_addr, o_rb_wr_data}, {43'h0, 1'b1, 8'h20, 16'h3333});
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        tick();
        readBeat(16'h0202);
        applyStimulus(1'b1, 1'b1, 16'h4444, 1'b0, 16'h0);
        tick();
        checkOutput("e_csn_race", {50'h0, o_rb_wr_en, o_err, o_xfer_cnt}, 68'h0);
        applyStimulus(1'b1, 1'b0, 16'h0130, 1'b0, 16'h0);
        tick();
        checkOutput("e_idle_next", {59'h0, o_rb_rd_en, o_rb_rd_addr}, {59'h0, 1'b1, 8'h30});
        applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
        tick();

        // Asynchronous reset mid-burst, then a header straight after release
        applyStimulus(1'b1, 1'b0, 16'h0260, 1'b0, 16'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'h5A5A);
        tick();
        checkOutput("f_pre_reset", {51'h0, o_spi_valid_tx, o_spi_out_data}, {51'h0, 1'b1, 16'h5A5A});
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("f_async_reset", outs(), 68'h0);
        checkOutput("f_reset_bmask", {52'h0, o_rb_wr_bmask}, {52'h0, 16'hFFFF});
        tick();
        i_rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0177, 1'b0, 16'h0);
        tick();
        checkOutput("f_first_hdr", {59'h0, o_rb_rd_en, o_rb_rd_addr}, {59'h0, 1'b1, 8'h77});
        applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
        tick();

        // Read-wait behaviour with the regbank never answering
        applyStimulus(1'b1, 1'b0, 16'h0150, 1'b0, 16'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
`ifdef SPI_RB_TIMEOUT_EN
        repeat (14) tick();
        checkOutput("g_before_timeout", {67'h0, o_err}, 68'h0);
        tick();
        checkOutput("g_timeout", {51'h0, o_err, o_spi_out_data}, {51'h0, 1'b1, 16'hFFFF});
`else
        repeat (100) tick();
        checkOutput("g_no_timeout", {65'h0, o_err, o_rb_rd_en, o_spi_valid_tx}, 68'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'h6B6B);
        tick();
        checkOutput("g_late_valid", {50'h0, o_err, o_spi_valid_tx, o_spi_out_data}, {50'h0, 1'b0, 1'b1, 16'h6B6B});
`endif
        applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
        tick();
        checkOutput("g_csn_clear", {67'h0, o_err}, 68'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
